// File: rtl/mig_app_pkg.sv
// Shared command encodings and executor decision type for the MIG app-interface responder.
package mig_app_pkg;

  localparam logic [2:0] CMD_WRITE  = 3'b000;
  localparam logic [2:0] CMD_READ   = 3'b001;
  localparam int         BEAT_SHIFT = 3;

  typedef enum logic [1:0] {
    EXEC_IDLE,
    EXEC_READ,
    EXEC_WRITE,
    EXEC_BAD
  } exec_t;

endpackage

// File: rtl/mig_app_responder_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and registered full/empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mig_app_responder.sv
// Behavioural stand-in for the MIG 7-series app interface: buffers commands and write
// data, executes them strictly in order against an internal array, returns reads after a fixed latency.
module mig_app_responder
  import mig_app_pkg::*;
#(
  parameter int ADDR_WIDTH   = 29,
  parameter int DATA_WIDTH   = 512,
  parameter int DEPTH_WORDS  = 64,
  parameter int FIFO_DEPTH   = 4,
  parameter int RD_LATENCY   = 8,
  parameter int CALIB_CYCLES = 100,
  parameter int STALL_PERIOD = 0
) (
  input  logic                    ui_clk,
  input  logic                    ui_clk_sync_rst,
  input  logic [ADDR_WIDTH-1:0]   app_addr,
  input  logic [2:0]              app_cmd,
  input  logic                    app_en,
  input  logic [DATA_WIDTH-1:0]   app_wdf_data,
  input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                    app_wdf_wren,
  input  logic                    app_wdf_end,
  output logic                    app_rdy,
  output logic                    app_wdf_rdy,
  output logic [DATA_WIDTH-1:0]   app_rd_data,
  output logic                    app_rd_data_valid,
  output logic                    app_rd_data_end,
  output logic                    init_calib_complete,
  output logic                    cmd_err
);

  localparam int IDX_W     = $clog2(DEPTH_WORDS);
  localparam int MASK_W    = DATA_WIDTH / 8;
  localparam int CMD_W     = 3 + IDX_W;
  localparam int WDF_W     = DATA_WIDTH + MASK_W;
  localparam int CAL_W     = $clog2(CALIB_CYCLES + 2);
  localparam int STALL_MOD = (STALL_PERIOD == 0) ? 1 : STALL_PERIOD;
  localparam int STALL_W   = $clog2(STALL_MOD + 1);

  logic [CAL_W-1:0]      cal_cnt;
  logic                  calib;
  logic [STALL_W-1:0]    stall_cnt;
  logic                  stall;
  logic                  cmd_full, cmd_empty, wdf_full, wdf_empty;
  logic                  cmd_pop, wdf_pop;
  logic [CMD_W-1:0]      cmd_head;
  logic [WDF_W-1:0]      wdf_head;
  logic [2:0]            head_cmd;
  logic [IDX_W-1:0]      head_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [MASK_W-1:0]     wr_mask;
  exec_t                 exec;
  logic                  unused_addr_bits;

  logic [DATA_WIDTH-1:0] mem  [DEPTH_WORDS];
  logic [RD_LATENCY-1:0] rd_v;
  logic [DATA_WIDTH-1:0] rd_d [RD_LATENCY];

  // Only the word-index field selects storage; beat offset and high bits alias.
  assign unused_addr_bits = ^{app_addr[ADDR_WIDTH-1:BEAT_SHIFT+IDX_W], app_addr[BEAT_SHIFT-1:0]};

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      cal_cnt <= CAL_W'(CALIB_CYCLES);
      calib   <= 1'b0;
    end else begin
      if (cal_cnt != '0) cal_cnt <= cal_cnt - 1'b1;
      if (cal_cnt <= CAL_W'(1)) calib <= 1'b1;
    end
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= (stall_cnt == STALL_W'(STALL_MOD - 1)) ? '0 : stall_cnt + 1'b1;
    end
  end

  assign stall       = (STALL_PERIOD != 0) && (stall_cnt == STALL_W'(STALL_MOD - 1));
  assign app_rdy     = calib && !cmd_full && !stall;
  assign app_wdf_rdy = calib && !wdf_full;

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .clk       (ui_clk),
    .rst       (ui_clk_sync_rst),
    .push      (app_en && app_rdy),
    .push_data ({app_cmd, app_addr[BEAT_SHIFT +: IDX_W]}),
    .pop       (cmd_pop),
    .pop_data  (cmd_head),
    .full      (cmd_full),
    .empty     (cmd_empty)
  );

  sync_fifo #(.WIDTH(WDF_W), .DEPTH(FIFO_DEPTH)) u_wdf_fifo (
    .clk       (ui_clk),
    .rst       (ui_clk_sync_rst),
    .push      (app_wdf_wren && app_wdf_rdy),
    .push_data ({app_wdf_data, app_wdf_mask}),
    .pop       (wdf_pop),
    .pop_data  (wdf_head),
    .full      (wdf_full),
    .empty     (wdf_empty)
  );

  assign head_cmd = cmd_head[CMD_W-1 -: 3];
  assign head_idx = cmd_head[IDX_W-1:0];
  assign wr_data  = wdf_head[WDF_W-1 -: DATA_WIDTH];
  assign wr_mask  = wdf_head[MASK_W-1:0];

  // A write with no data yet holds the head, so later reads wait behind it.
  always_comb begin
    exec = EXEC_IDLE;
    if (!cmd_empty) begin
      if (head_cmd == CMD_READ)       exec = EXEC_READ;
      else if (head_cmd == CMD_WRITE) exec = wdf_empty ? EXEC_IDLE : EXEC_WRITE;
      else                            exec = EXEC_BAD;
    end
  end

  assign cmd_pop = (exec != EXEC_IDLE);
  assign wdf_pop = (exec == EXEC_WRITE);

  always_ff @(posedge ui_clk) begin
    if (!ui_clk_sync_rst && exec == EXEC_WRITE) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!wr_mask[b]) mem[head_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      rd_v <= '0;
      for (int i = 0; i < RD_LATENCY; i++) rd_d[i] <= '0;
    end else begin
      rd_v[0] <= (exec == EXEC_READ);
      rd_d[0] <= (exec == EXEC_READ) ? mem[head_idx] : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_v[i] <= rd_v[i-1];
        rd_d[i] <= rd_d[i-1];
      end
    end
  end

  assign app_rd_data         = rd_d[RD_LATENCY-1];
  assign app_rd_data_valid   = rd_v[RD_LATENCY-1];
  assign app_rd_data_end     = rd_v[RD_LATENCY-1];
  assign init_calib_complete = calib;

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      cmd_err <= 1'b0;
    end else if (exec == EXEC_BAD || (app_wdf_rdy && (app_wdf_wren != app_wdf_end))) begin
      cmd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mig_app_responder.sv
// Directed-plus-random bench for mig_app_responder against a word-array reference model.
module tb_mig_app_responder;

  localparam int AW    = 29;
  localparam int DW    = 512;
  localparam int MW    = DW / 8;
  localparam int DEPTH = 64;
  localparam int FD    = 4;
  localparam int LAT   = 8;
  localparam int CAL   = 100;
  localparam int STALL = 5;

  logic          ui_clk = 1'b0;
  logic          ui_clk_sync_rst;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic [DW-1:0] app_wdf_data;
  logic [MW-1:0] app_wdf_mask;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic          app_rdy;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          app_rd_data_end;
  logic          init_calib_complete;
  logic          cmd_err;

  always #5 ui_clk = ~ui_clk;

  mig_app_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH), .FIFO_DEPTH(FD),
    .RD_LATENCY(LAT), .CALIB_CYCLES(CAL), .STALL_PERIOD(STALL)
  ) dut (
    .ui_clk              (ui_clk),
    .ui_clk_sync_rst     (ui_clk_sync_rst),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_rdy             (app_rdy),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end),
    .init_calib_complete (init_calib_complete),
    .cmd_err             (cmd_err)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference: one word per index, reads answered in issue order.
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] exp_q [$];
  int            valid_cyc [$];
  int            got = 0;
  int            stray = 0;
  bit            watch_stray = 0;
  logic [DW-1:0] last_rd;

  always @(posedge ui_clk) begin
    if (ui_clk_sync_rst) cyc <= 0;
    else                 cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge ui_clk) begin
    if (!ui_clk_sync_rst && app_rd_data_valid) begin
      got++;
      valid_cyc.push_back(cyc);
      last_rd = app_rd_data;
      if (watch_stray) stray++;
      chk("rd_end", app_rd_data_end, 1);
      if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
      else                   chk("rd_data", app_rd_data, exp_q.pop_front());
    end
  end

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'((a >> 3) % DEPTH);
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    logic [DW-1:0] w;
    w = mem_m[idx_of(a)];
    for (int b = 0; b < MW; b++) if (!m[b]) w[b*8 +: 8] = d[b*8 +: 8];
    mem_m[idx_of(a)] = w;
  endfunction

  function automatic void model_read(input logic [AW-1:0] a);
    exp_q.push_back(mem_m[idx_of(a)]);
  endfunction

  task automatic send_cmd(input logic [2:0] c, input logic [AW-1:0] a, output int acc);
    int t;
    t = 0;
    @(negedge ui_clk);
    app_en = 1'b1; app_cmd = c; app_addr = a;
    while (!app_rdy && t < 500) begin
      @(negedge ui_clk);
      t++;
    end
    acc = cyc;
    if (t >= 500) chk("cmd_timeout", 1, 0);
    @(posedge ui_clk);
    #1 app_en = 1'b0;
  endtask

  task automatic send_data(input logic [DW-1:0] d, input logic [MW-1:0] m, input logic e);
    int t;
    t = 0;
    @(negedge ui_clk);
    app_wdf_wren = 1'b1; app_wdf_end = e; app_wdf_data = d; app_wdf_mask = m;
    while (!app_wdf_rdy && t < 500) begin
      @(negedge ui_clk);
      t++;
    end
    if (t >= 500) chk("wdf_timeout", 1, 0);
    @(posedge ui_clk);
    #1 app_wdf_wren = 1'b0;
    app_wdf_end = 1'b0;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    int acc;
    model_write(a, d, m);
    fork
      send_cmd(3'b000, a, acc);
      send_data(d, m, 1'b1);
    join
  endtask

  task automatic read_word(input logic [AW-1:0] a, output int acc);
    model_read(a);
    send_cmd(3'b001, a, acc);
  endtask

  task automatic wait_reads(input int target);
    int t;
    t = 0;
    while (got < target && t < 1000) begin
      @(negedge ui_clk);
      t++;
    end
    repeat (2) @(negedge ui_clk);
    chk("rd_count", got, target);
  endtask

  initial begin
    int            acc, acc0, base, g0, t;
    logic [31:0]   w32;
    logic [DW-1:0] d;
    logic [MW-1:0] m;
    logic [AW-1:0] a;

    ui_clk_sync_rst = 1'b1;
    app_en = 0; app_cmd = 0; app_addr = 0;
    app_wdf_data = 0; app_wdf_mask = 0; app_wdf_wren = 0; app_wdf_end = 0;
    repeat (3) @(negedge ui_clk);
    chk("rst_app_rdy",   app_rdy, 0);
    chk("rst_wdf_rdy",   app_wdf_rdy, 0);
    chk("rst_calib",     init_calib_complete, 0);
    chk("rst_rd_valid",  app_rd_data_valid, 0);
    chk("rst_rd_end",    app_rd_data_end, 0);
    chk("rst_rd_data",   app_rd_data, 0);
    chk("rst_cmd_err",   cmd_err, 0);

    // Calibration window and stall phase; the cycle of reset release is cycle 0.
    ui_clk_sync_rst = 1'b0;
    while (cyc <= CAL + 1) begin
      chk("calib",     init_calib_complete, cyc >= CAL);
      chk("cal_rdy",   app_rdy, (cyc >= CAL) && (cyc % STALL != STALL - 1));
      chk("cal_wdf",   app_wdf_rdy, cyc >= CAL);
      @(negedge ui_clk);
    end

    // Eight sequential words, then read them back and time the first return.
    for (int i = 0; i < 8; i++) begin
      w32 = 32'hA5A5_0000 + i;
      d = {16{w32}};
      write_word(AW'(i * 8), d, '0);
    end
    repeat (4) @(negedge ui_clk);
    base = got;
    acc0 = 0;
    for (int i = 0; i < 8; i++) begin
      read_word(AW'(i * 8), acc);
      if (i == 0) acc0 = acc;
    end
    wait_reads(base + 8);
    chk("rd_latency", valid_cyc[base], acc0 + 1 + LAT);

    // Byte mask: masked low half keeps the earlier all-ones pattern.
    write_word('0, {DW{1'b1}}, '0);
    write_word('0, '0, 64'h0000_0000_FFFF_FFFF);
    g0 = got;
    read_word('0, acc);
    wait_reads(g0 + 1);
    chk("mask_word", last_rd, {{(DW/2){1'b0}}, {(DW/2){1'b1}}});

    // Write command ahead of its data: the following read must wait for it.
    d = rand_word();
    a = AW'(16 * 8);
    model_write(a, d, '0);
    model_read(a);
    g0 = got;
    send_cmd(3'b000, a, acc);
    send_cmd(3'b001, a, acc);
    repeat (LAT + 4) @(negedge ui_clk);
    chk("read_blocked", got, g0);
    send_data(d, '0, 1'b1);
    wait_reads(g0 + 1);
    chk("late_data_word", last_rd, d);

    // Data ahead of its command, using an aliased address for the write.
    d = rand_word();
    a = AW'(17 * 8) | (AW'(1) << 20) | AW'(3);
    model_write(a, d, '0);
    model_read(AW'(17 * 8));
    g0 = got;
    send_data(d, '0, 1'b1);
    repeat (3) @(negedge ui_clk);
    send_cmd(3'b000, a, acc);
    send_cmd(3'b001, AW'(17 * 8), acc);
    wait_reads(g0 + 1);
    chk("early_data_word", last_rd, d);

    // Random traffic over already-initialised words, random aliasing bits and masks.
    g0 = got;
    base = 0;
    for (int k = 0; k < 24; k++) begin
      a = AW'($urandom);
      a[8:3] = 6'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        d = rand_word();
        m = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : '0;
        write_word(a, d, m);
      end else begin
        read_word(a, acc);
        base++;
      end
    end
    wait_reads(g0 + base);

    // Empty FIFO: app_rdy drops only on stall cycles.
    repeat (3) @(negedge ui_clk);
    for (int k = 0; k < 10; k++) begin
      chk("stall_pattern", app_rdy, cyc % STALL != STALL - 1);
      @(negedge ui_clk);
    end

    // Blocked write plus reads fill the command FIFO; then release with data.
    d = rand_word();
    a = AW'(20 * 8);
    model_write(a, d, '0);
    g0 = got;
    send_cmd(3'b000, a, acc);
    for (int k = 0; k < 3; k++) read_word((k % 2 == 0) ? a : AW'(k * 8), acc);
    for (int k = 0; k < 5; k++) begin
      @(negedge ui_clk);
      chk("full_rdy", app_rdy, 0);
    end
    chk("full_no_return", got, g0);
    fork
      begin
        for (int k = 3; k < 6; k++) read_word((k % 2 == 0) ? a : AW'(k * 8), acc);
      end
      begin
        repeat (2) @(negedge ui_clk);
        send_data(d, '0, 1'b1);
      end
    join
    wait_reads(g0 + 6);
    chk("stall_all_returned", exp_q.size(), 0);

    // Bad command encoding is accepted and latches the error flag.
    chk("err_clean", cmd_err, 0);
    send_cmd(3'b010, '0, acc);
    repeat (3) @(negedge ui_clk);
    chk("err_set", cmd_err, 1);
    repeat (10) @(negedge ui_clk);
    chk("err_sticky", cmd_err, 1);

    // Reset with reads in flight: nothing returns, calibration restarts.
    g0 = got;
    for (int k = 0; k < 3; k++) read_word(AW'(k * 8), acc);
    @(negedge ui_clk);
    ui_clk_sync_rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge ui_clk);
    chk("rst2_valid",  app_rd_data_valid, 0);
    chk("rst2_err",    cmd_err, 0);
    chk("rst2_rdy",    app_rdy, 0);
    chk("rst2_calib",  init_calib_complete, 0);
    ui_clk_sync_rst = 1'b0;
    watch_stray = 1;
    repeat (40) @(negedge ui_clk);
    chk("rst2_stray", stray, 0);
    chk("rst2_no_return", got, g0);
    chk("rst2_calib_mid", init_calib_complete, 0);
    t = 0;
    while (!init_calib_complete && t < 300) begin
      @(negedge ui_clk);
      t++;
    end
    chk("recal_cycle", cyc, CAL);

    // Write data with end not matching wren flags a protocol error.
    send_data(rand_word(), '0, 1'b0);
    repeat (2) @(negedge ui_clk);
    chk("wdf_end_err", cmd_err, 1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mig_app_responder.md
# mig_app_responder

Behavioural responder for the MIG 7-series user (app) interface, used as the DDR3 controller stand-in in simulation benches. It accepts write/read commands and write data exactly as an app-side initiator drives them, stores 512-bit words in an internal array and returns read data in order after a fixed latency. Initiator test logic is therefore verified without the MIG IP, DDR3 memory model or clock wizard.

## Interface
Parameters:
- ADDR_WIDTH, 29, app_addr width; units are 64-bit beats.
- DATA_WIDTH, 512, app data width (one BL8 word).
- DEPTH_WORDS, 64, array size in DATA_WIDTH words; power of two.
- FIFO_DEPTH, 4, command FIFO and write-data FIFO depth; power of two.
- RD_LATENCY, 8, cycles from read execution to app_rd_data_valid; ≥1.
- CALIB_CYCLES, 100, cycles from reset release to init_calib_complete.
- STALL_PERIOD, 0, if nonzero, app_rdy is forced low one cycle in every STALL_PERIOD; 0 disables.

Ports:
- ui_clk  in  1  clock; one clock only.
- ui_clk_sync_rst  in  1  reset, synchronous, active-high.
- app_addr  in  ADDR_WIDTH  command address.
- app_cmd  in  3  000 write, 001 read.
- app_en  in  1  command valid.
- app_wdf_data  in  DATA_WIDTH  write data.
- app_wdf_mask  in  DATA_WIDTH/8  byte mask, 1 = byte not written.
- app_wdf_wren  in  1  write data valid.
- app_wdf_end  in  1  last beat; must equal app_wdf_wren.
- app_rdy  out  1  command accepted when app_en && app_rdy.
- app_wdf_rdy  out  1  data accepted when app_wdf_wren && app_wdf_rdy.
- app_rd_data  out  DATA_WIDTH  read data.
- app_rd_data_valid  out  1  read data valid.
- app_rd_data_end  out  1  equals app_rd_data_valid.
- init_calib_complete  out  1  calibration done.
- cmd_err  out  1  sticky protocol error flag.

## Operation
- Calibration counter counts CALIB_CYCLES after reset; init_calib_complete then stays high until next reset.
- app_rdy = calib && cmd FIFO not full && not stall cycle. app_wdf_rdy = calib && wdf FIFO not full.
- Accepted commands push {cmd, addr} into cmd FIFO; accepted data push {data, mask} into wdf FIFO. Data may precede, coincide with, or follow its write command.
- Executor, one command per cycle from cmd FIFO head:
  - read: always executes; array word read, pushed into RD_LATENCY-stage valid/data pipeline.
  - write: executes only when wdf FIFO non-empty; pops both; unmasked bytes written. Otherwise head stalls (blocks later reads: strict in-order).
  - other cmd encodings: popped, no effect, cmd_err set.
- Word index = app_addr[3 +: log2(DEPTH_WORDS)]; low 3 bits and upper bits ignored (addresses alias/wrap).
- app_wdf_wren != app_wdf_end while app_wdf_rdy sets cmd_err; data still accepted on wren.
- Array contents are not reset; uninitialised words read as X in simulation.

## Timing
- Reset values: app_rdy 0, app_wdf_rdy 0, init_calib_complete 0, app_rd_data_valid 0, app_rd_data_end 0, app_rd_data 0, cmd_err 0.
- init_calib_complete rises on cycle CALIB_CYCLES after the first cycle with reset low; app_rdy/app_wdf_rdy may rise the same cycle.
- Command accepted at N with empty FIFO: executes at N+1; read data valid at N+1+RD_LATENCY.
- Write executed at E is visible to a read executed at E+1 or later.
- Full FIFO: ready low that cycle; a pop in the same cycle does not raise ready until next cycle (registered full).
- Stall cycle counter free-runs from reset release.
- Reset mid-operation: FIFOs, executor and read pipeline flushed; in-flight reads never return; calibration restarts.

## Structure
- Package mig_app_pkg: CMD_WRITE = 3'b000, CMD_READ = 3'b001, BEAT_SHIFT = 3.
- Sub-module sync_fifo (parameterised width/depth, full/empty, same-cycle push/pop), instantiated for cmd and wdf FIFOs.
- Top holds calibration counter, stall counter, executor, array and read pipeline.

## Test plan
- Reset, CALIB_CYCLES=100 -> init_calib_complete and app_rdy 0 through cycle 99, 1 at cycle 100; all outputs at reset values.
- Write 8 words addr 0,8..56 data = {16{32'hA5A5_0000 + i}}, then read same addresses -> 8 valid beats in order, correct data, first valid 1+RD_LATENCY after its read acceptance.
- Write all-FF to addr 0, then write 0 with mask 64'h0000_0000_FFFF_FFFF, read -> low 32 bytes FF, upper 32 bytes 00.
- Write command at N, data at N+3 -> following read to same addr at N+1 returns new data (blocked behind write); data-before-command case gives same result.
- Issue 6 back-to-back reads with STALL_PERIOD=5 -> app_rdy low on stall cycles and when 4 pending; all 6 returned in order, none lost or duplicated.
- app_cmd 3'b010 accepted -> cmd_err 1 and stays 1; reset asserted with 3 reads in flight -> no app_rd_data_valid after reset, cmd_err 0.
